// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment
// digits. A packed hex word is staged on a load strobe. It is moved into a
// shadow register only at frame start, so a frame never mixes old and new
// digits. One digit at a time is scanned. Each digit visit is a GAP period with
// all anodes off, then a SHOW period with exactly one anode on.
//
// Parameters
//   NUM_DIGITS   digits scanned (>=1)
//   REFRESH_DIV  clk cycles each digit is lit per visit (>=1)
//   GAP_CYCLES   clk cycles with all digits off before each visit (0 = none)
//   AN_ACT_LOW   1: an_out active-low, 0: an_out active-high
//
// Optional feature macro
//   LEADING_ZERO_BLANK_EN  when defined, a digit k>0 is blanked (segments off,
//                          anode still driven) when its nibble and every higher
//                          nibble are zero and no decimal point at or above it
//                          is lit. Digit 0 is never blanked.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous reset, active-low
//   en          in   scan enable; 0 blanks the display and restarts the scan
//   load        in   1-cycle strobe capturing data_in / dp_in into staging
//   data_in     in   digit k = data_in[4k+3:4k]; digit 0 is the rightmost
//   dp_in       in   decimal point per digit, 1 = lit
//   seg_out     out  {a,b,c,d,e,f,g}, active-low
//   dp_out      out  decimal point, active-low
//   an_out      out  one-hot digit enable, polarity set by AN_ACT_LOW
//   frame_done  out  1-cycle pulse after the last digit's SHOW period ends
//
// Handshake: load is a plain strobe with no back-pressure. Every cycle with
// load=1 is accepted, and the most recent load before a frame start wins.
//
// Timing: all outputs are registered. They reflect the state and digit index
// of the previous cycle. The exception is en=0: it blanks the outputs on the
// same edge that sends the FSM to IDLE.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    // -------------------------------------------------------------------------
    // Sizing. Each counter only has to reach (max - 1). $clog2 of the maximum
    // is therefore enough, with a floor of 1 bit so every vector stays legal.
    // -------------------------------------------------------------------------
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? {NUM_DIGITS{1'b1}}
                                                          : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    // With no gap configured, each visit chains directly from SHOW to SHOW.
    localparam logic [1:0] ST_AFTER_SHOW = (GAP_CYCLES > 0) ? ST_GAP : ST_SHOW;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]              state_q,     state_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic [DIV_W-1:0]        div_q,       div_d;
    logic [GAP_W-1:0]        gap_q,       gap_d;

    logic [4*NUM_DIGITS-1:0] stage_q,     stage_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q,  stage_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q,    shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q,   pending_d;

    logic [6:0]              seg_q,       seg_d;
    logic                    dp_q,        dp_d;
    logic [NUM_DIGITS-1:0]   an_q,        an_d;
    logic                    fdone_q,     fdone_d;

    // High for one cycle when the scan (re)enters digit 0 from IDLE or from
    // the wrap. This is the only point where the shadow register may change.
    logic                    frame_start;

    // -------------------------------------------------------------------------
    // Nibble to active-low segment decode, bit order {a,b,c,d,e,f,g}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Scan FSM: state, digit index, divider and gap counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        div_d       = div_q;
        gap_d       = gap_q;
        frame_start = 1'b0;
        fdone_d     = 1'b0;

        if (!en) begin
            // Dropping the enable abandons the frame wherever it was.
            state_d = ST_IDLE;
            idx_d   = '0;
            div_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_start = 1'b1;
                    idx_d       = '0;
                    div_d       = '0;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES > 0) ? ST_GAP : ST_SHOW;
                end

                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        state_d = ST_AFTER_SHOW;
                        if (idx_q == LAST_IDX) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                            fdone_d     = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    div_d   = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Staging / shadow. A load in the frame-start cycle bypasses staging, so
    // that value is used for the frame that is starting.
    // -------------------------------------------------------------------------
    always_comb begin
        stage_d     = stage_q;
        stage_dp_d  = stage_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;

        if (load) begin
            stage_d    = data_in;
            stage_dp_d = dp_in;
            pending_d  = 1'b1;
        end

        if (frame_start) begin
            if (load) begin
                shadow_d    = data_in;
                shadow_dp_d = dp_in;
            end else if (pending_q) begin
                shadow_d    = stage_q;
                shadow_dp_d = stage_dp_q;
            end
            pending_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero blanking mask, built from the top digit downward.
    // -------------------------------------------------------------------------
    logic digit_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (shadow_q[4*k +: 4] == 4'h0) && !shadow_dp_q[k];
            lz_blank[k] = upper_zero;
        end
    end

    assign digit_blank = lz_blank[idx_q];
`else
    assign digit_blank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Output decode (registered below)
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [3:0]            cur_nib;

    assign an_onehot = NUM_DIGITS'(1) << idx_q;
    assign cur_nib   = shadow_q[4*int'(idx_q) +: 4];

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = AN_OFF;
        if (en && (state_q == ST_SHOW)) begin
            an_d  = AN_ACT_LOW ? ~an_onehot : an_onehot;
            seg_d = digit_blank ? SEG_BLANK : hex_to_seg(cur_nib);
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            stage_q     <= '0;
            stage_dp_q  <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            stage_q     <= stage_d;
            stage_dp_q  <= stage_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fdone_q     <= fdone_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1
// and AN_ACT_LOW=1.
//
// The reference model treats a running scan as a cycle count since the enable
// edge. Position in the frame, digit number and gap/show phase come from that
// count by division. Frame data is whatever was most recently loaded at the
// edge that begins the frame.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int D = 4;
  localparam int G = 1;
  localparam int SLOT = G + D;
  localparam int P = N * SLOT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [6:0]     seg_out;
  logic           dp_out;
  logic [N-1:0]   an_out;
  logic           frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(D),
    .GAP_CYCLES (G),
    .AN_ACT_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", 0, 1);
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model state
  int             m_c;        // cycles since enable edge, -1 when idle
  logic [4*N-1:0] m_stg;
  logic [N-1:0]   m_stg_dp;
  logic [4*N-1:0] m_frm;
  logic [N-1:0]   m_frm_dp;
  logic [N-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dp;
  logic           exp_fd;

  function automatic logic [6:0] ref_decode(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tbl[v];
  endfunction

  function automatic logic ref_blank(input int k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    return ((m_frm >> (4 * k)) == 0) && ((m_frm_dp >> k) == 0);
`else
    return (k < 0);
`endif
  endfunction

  // Advance one clock. The expected outputs after the edge come from the model
  // position before the edge. The inputs seen at the edge then update the model.
  task automatic tick();
    int p;
    int dig;
    @(posedge clk);
    cyc++;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_fd  = 1'b0;
    if (en && m_c >= 0) begin
      p   = m_c % P;
      dig = p / SLOT;
      if ((p % SLOT) >= G) begin
        exp_an  = ~(4'b0001 << dig);
        exp_seg = ref_blank(dig) ? 7'h7F : ref_decode(m_frm[4*dig +: 4]);
        exp_dp  = ~m_frm_dp[dig];
      end
      exp_fd = (p == P - 1);
    end
    if (load) begin
      m_stg    = data_in;
      m_stg_dp = dp_in;
    end
    if (!en) begin
      m_c = -1;
    end else if (m_c < 0) begin
      m_c      = 0;
      m_frm    = m_stg;
      m_frm_dp = m_stg_dp;
    end else begin
      m_c++;
      if (m_c % P == 0) begin
        m_frm    = m_stg;
        m_frm_dp = m_stg_dp;
      end
    end
    #1;
  endtask

  task automatic drive_load(input logic [4*N-1:0] d, input logic [N-1:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
  endtask

  task automatic model_reset();
    m_c      = -1;
    m_stg    = '0;
    m_stg_dp = '0;
    m_frm    = '0;
    m_frm_dp = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (an_out !== 4'hF) begin
      bad++; $display("FAIL reset_an got=%b want=%b", an_out, 4'hF);
    end
    total++;
    if (seg_out !== 7'h7F) begin
      bad++; $display("FAIL reset_seg got=%b want=%b", seg_out, 7'h7F);
    end
    total++;
    if (dp_out !== 1'b1) begin
      bad++; $display("FAIL reset_dp got=%b want=1", dp_out);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_fd got=%b want=0", frame_done);
    end
    total++;
  endtask

  task automatic test_scan();
    int fd_count;
    fd_count = 0;
    drive_load(16'h1234, 4'b0000);
    en = 1'b1;
    for (int i = 0; i < 41; i++) begin
      tick();
      load = 1'b0;
      if (frame_done === 1'b1) fd_count++;
      if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        bad++;
        $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      total++;
    end
    if (fd_count !== 2) begin
      bad++; $display("FAIL scan_frame_done_count got=%0d want=2", fd_count);
    end
    total++;
  endtask

  task automatic test_tear_free();
    int guard;
    logic [6:0] seen_d3;
    logic [6:0] seen_d0;
    logic fd_seen;
    guard = 0;
    while (!((m_c % P) / SLOT == 2 && (m_c % P) % SLOT >= G) && guard < 3 * P) begin
      tick();
      guard++;
    end
    if (guard >= 3 * P) begin
      bad++; $display("FAIL tear_wait got=timeout want=digit2_lit");
    end
    total++;
    drive_load(16'hABCD, 4'b0000);
    seen_d3 = 7'h7F;
    seen_d0 = 7'h7F;
    fd_seen = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      load = 1'b0;
      if (!fd_seen && an_out == 4'b0111) seen_d3 = seg_out;
      if (fd_seen && an_out == 4'b1110 && seen_d0 == 7'h7F) seen_d0 = seg_out;
      if (frame_done === 1'b1) fd_seen = 1'b1;
      if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        bad++;
        $display("FAIL tear cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      total++;
    end
    if (seen_d3 !== 7'b1001111) begin
      bad++; $display("FAIL tear_old_digit3 got=%b want=%b", seen_d3, 7'b1001111);
    end
    total++;
    if (seen_d0 !== 7'b1000010) begin
      bad++; $display("FAIL tear_new_digit0 got=%b want=%b", seen_d0, 7'b1000010);
    end
    total++;
  endtask

  task automatic test_decode_sweep();
    logic [11:0] upper;
    for (int v = 0; v < 16; v++) begin
      upper = 12'($urandom_range(0, 4095));
      drive_load({upper, 4'(v)}, 4'b0001);
      for (int i = 0; i < 2 * P; i++) begin
        tick();
        load = 1'b0;
        if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
          bad++;
          $display("FAIL decode v=%0d cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                   v, cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
        end
        total++;
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard;
    guard = 0;
    while (!(m_c >= 0 && (m_c % P) % SLOT < G) && guard < 3 * P) begin
      tick();
      guard++;
    end
    if (guard >= 3 * P) begin
      bad++; $display("FAIL drop_wait got=timeout want=gap_state");
    end
    total++;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (an_out !== 4'hF || {an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        bad++;
        $display("FAIL drop_idle cyc=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                 cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
      end
      total++;
    end
    en = 1'b1;
    for (int i = 1; i <= P; i++) begin
      tick();
      // one gap cycle plus one cycle of output register: digit 0 on the 3rd edge
      if (i == 3 && an_out !== 4'b1110) begin
        bad++; $display("FAIL drop_restart_digit0 got=%b want=%b", an_out, 4'b1110);
      end
      if (i == 3) total++;
      if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        bad++;
        $display("FAIL drop_resume cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      total++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0)
        drive_load(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
      tick();
      load = 1'b0;
      if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        bad++;
        $display("FAIL random cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      total++;
    end
    en = 1'b1;
  endtask

  task automatic test_leading_zero();
    logic [N-1:0] dps [2];
    dps[0] = 4'b0000;
    dps[1] = 4'b0100;
    for (int t = 0; t < 2; t++) begin
      drive_load(16'h0050, dps[t]);
      for (int i = 0; i < 2 * P; i++) begin
        tick();
        load = 1'b0;
        if ({an_out, seg_out, dp_out, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
          bad++;
          $display("FAIL lzero t=%0d cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                   t, cyc, an_out, seg_out, dp_out, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
        end
        total++;
      end
    end
  endtask

  task automatic test_reset_mid_show();
    int guard;
    en = 1'b1;
    guard = 0;
    while (!(an_out == 4'b1011) && guard < 3 * P) begin
      tick();
      guard++;
    end
    if (guard >= 3 * P) begin
      bad++; $display("FAIL rst_mid_wait got=timeout want=digit_lit");
    end
    total++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({an_out, seg_out, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               an_out, seg_out, dp_out, frame_done);
    end
    total++;
    en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (an_out !== 4'hF) begin
        bad++; $display("FAIL rst_mid_hold got=%b want=1111", an_out);
      end
      total++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_tear_free();
    test_decode_sweep();
    test_enable_drop();
    test_random();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    test_reset_mid_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
